// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone initiator: FSM state encoding and
// default bus geometry / timeout.
package wb_pkg;

    localparam int DEF_AW      = 32;
    localparam int DEF_DW      = 32;
    localparam int DEF_TIMEOUT = 255;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } wb_state_e;

endpackage

// File: rtl/wb_initiator.sv
// Single-outstanding Wishbone classic initiator: accepts one core request,
// runs one bus cycle (ack / err / timeout), then pulses a one-cycle response.
module wb_initiator
    import wb_pkg::*;
#(
    parameter int AW      = DEF_AW,
    parameter int DW      = DEF_DW,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,

    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic          req_we_i,
    input  logic [AW-1:0] req_adr_i,
    input  logic [DW-1:0] req_wdata_i,
    input  logic [3:0]    req_sel_i,

    output logic          rsp_valid_o,
    output logic [DW-1:0] rsp_rdata_o,
    output logic          rsp_err_o,

    output logic          wb_cyc_o,
    output logic          wb_stb_o,
    output logic          wb_we_o,
    output logic [AW-1:0] wb_adr_o,
    output logic [DW-1:0] wb_dat_o,
    output logic [3:0]    wb_sel_o,
    input  logic [DW-1:0] wb_dat_i,
    input  logic          wb_ack_i,
    input  logic          wb_err_i
);

    // A zero TIMEOUT still needs a legal (1-bit) counter; it is simply never compared.
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    wb_state_e       r_state;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_inc;
    logic            w_timeout;

    assign req_ready_o = (r_state == ST_IDLE);

    // Timeout fires on the edge that would move the count onto TIMEOUT, so the
    // bus cycle lasts exactly TIMEOUT clocks; ack/err on that edge still win.
    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_timeout = (TIMEOUT != 0) && (w_cnt_inc == CW'(TIMEOUT));

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            wb_cyc_o    <= 1'b0;
            wb_stb_o    <= 1'b0;
            wb_we_o     <= 1'b0;
            wb_adr_o    <= '0;
            wb_dat_o    <= '0;
            wb_sel_o    <= 4'h0;
            rsp_valid_o <= 1'b0;
            rsp_err_o   <= 1'b0;
            rsp_rdata_o <= '0;
        end else begin
            // NOTE: default-low keeps rsp_valid_o a single-cycle pulse; only a termination raises it.
            rsp_valid_o <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        wb_we_o  <= req_we_i;
                        wb_adr_o <= req_adr_i;
                        wb_dat_o <= req_wdata_i;
                        wb_sel_o <= req_sel_i;
                        wb_cyc_o <= 1'b1;
                        wb_stb_o <= 1'b1;
                        r_cnt    <= '0;
                        r_state  <= ST_BUS;
                    end
                end
                ST_BUS: begin
                    if (wb_err_i || wb_ack_i || w_timeout) begin
                        wb_cyc_o    <= 1'b0;
                        wb_stb_o    <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        r_state     <= ST_RESP;
                        if (wb_err_i) begin
                            rsp_err_o <= 1'b1;
                        end else if (wb_ack_i) begin
                            rsp_err_o <= 1'b0;
                            if (!wb_we_o) begin
                                rsp_rdata_o <= wb_dat_i;
                            end
                        end else begin
                            rsp_err_o <= 1'b1;
                        end
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/wb_initiator.md
WB_INITIATOR -- requirements
Module: wb_initiator

Interface
- REQ-001 SHALL have parameter AW, default 32: Wishbone address width.
- REQ-002 SHALL have parameter DW, default 32: data width, fixed at 32 with 4 byte selects.
- REQ-003 SHALL have parameter TIMEOUT, default 255: maximum bus cycles spent waiting for ack/err; 0 disables the timeout.
- REQ-004 SHALL have port wb_clk_i, input, 1: the single clock; all logic on its rising edge.
- REQ-005 SHALL have port wb_rst_i, input, 1: asynchronous, active-high reset.
- REQ-006 SHALL have port req_valid_i, input, 1: core request present.
- REQ-007 SHALL have port req_ready_o, output, 1: request accepted when high together with req_valid_i.
- REQ-008 SHALL have the following request inputs: req_we_i (1, write), req_adr_i (AW, byte address), req_wdata_i (DW, write data) and req_sel_i (4, byte selects).
- REQ-009 SHALL have port rsp_valid_o, output, 1: a one-cycle response pulse.
- REQ-010 SHALL have port rsp_rdata_o, output, DW: read data, valid with rsp_valid_o.
- REQ-011 SHALL have port rsp_err_o, output, 1: error/timeout flag, valid with rsp_valid_o.
- REQ-012 SHALL have the following Wishbone outputs: wb_cyc_o (1), wb_stb_o (1), wb_we_o (1), wb_adr_o (AW), wb_dat_o (DW) and wb_sel_o (4).
- REQ-013 SHALL have the following Wishbone inputs: wb_dat_i (DW), wb_ack_i (1) and wb_err_i (1).

Function
- REQ-014 SHALL implement the FSM states IDLE, BUS and RESP.
- REQ-015 SHALL drive req_ready_o=1 only in IDLE, combinationally from the state.
- REQ-016 In IDLE, on req_valid_i&req_ready_o at edge N, the block SHALL latch we/adr/wdata/sel onto wb_*_o, set wb_cyc_o=wb_stb_o=1 from edge N onward, clear the timeout counter and go to BUS.
- REQ-017 In BUS, wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o and wb_sel_o SHALL stay stable until termination.
- REQ-018 In BUS, when wb_ack_i=1 at an edge, the block SHALL capture wb_dat_i into rsp_rdata_o (reads only; writes leave it unchanged), set rsp_err_o=0, deassert wb_cyc_o/wb_stb_o and go to RESP.
- REQ-019 In BUS, when wb_err_i=1 at an edge, the block SHALL set rsp_err_o=1, deassert cyc/stb and go to RESP; err SHALL take priority over a simultaneous ack.
- REQ-020 The timeout counter SHALL be ceil(log2(TIMEOUT+1)) bits wide and increment once per BUS cycle without termination.
- REQ-021 When TIMEOUT≠0 and the counter reaches TIMEOUT, the block SHALL terminate as an error (rsp_err_o=1) and go to RESP.
- REQ-022 An ack or err arriving in the same cycle as the timeout SHALL win over the timeout.
- REQ-023 In RESP, rsp_valid_o SHALL be 1 for exactly one cycle, and the block SHALL then return to IDLE.
- REQ-024 A zero-wait responder (ack=cyc&stb) SHALL give the following timing: accept at edge N, ack sampled at N+1, rsp_valid_o high during the cycle after N+1, and req_ready_o high again at N+3.
- REQ-025 wb_ack_i/wb_err_i seen in IDLE or RESP SHALL be ignored and SHALL NOT produce a response.
- REQ-026 There SHALL be no pipelining: at most one outstanding transaction, and req_valid_i is ignored outside IDLE.
- REQ-027 wb_we_o, wb_adr_o, wb_dat_o and wb_sel_o SHALL hold their last values after termination; they are don't-care while cyc is low.

Reset
- REQ-028 While wb_rst_i=1, asynchronously: state=IDLE; wb_cyc_o, wb_stb_o, wb_we_o, rsp_valid_o, rsp_err_o=0; wb_adr_o, wb_dat_o, rsp_rdata_o=0; wb_sel_o=4'h0; counter=0.
- REQ-029 req_ready_o SHALL be 1 during and immediately after reset, because the state is IDLE.
- REQ-030 Reset during BUS or RESP SHALL abort the transaction with no response pulse, and cyc/stb SHALL drop in the same instant.

Structure
- REQ-031 Shared package wb_pkg SHALL hold the FSM state enum, the default AW/DW and the default TIMEOUT constant.
- REQ-032 The design SHALL be a single module with no sub-modules; the counter and FSM are inline.

Verification
- REQ-033 Zero-wait write to GPIO-style responder: adr=0x4, wdata=0xA5, sel=0001 -> cyc/stb high 1 cycle, responder out[7:0]=0xA5, one rsp_valid_o pulse with rsp_err_o=0.
- REQ-034 Read with responder returning 0xDEADBEEF after 3 wait states -> cyc held 4 cycles, address stable, rsp_rdata_o=0xDEADBEEF, rsp_err_o=0.
- REQ-035 TIMEOUT=4 with a silent responder -> cyc drops after 4 BUS cycles, rsp_err_o=1, req_ready_o returns high.
- REQ-036 ack and err asserted together -> rsp_err_o=1; with TIMEOUT=4, ack asserted on the 4th BUS cycle -> rsp_err_o=0.
- REQ-037 Reset asserted mid-BUS -> cyc/stb/rsp_valid_o go to 0 immediately, no response pulse follows, and the next request completes normally.
- REQ-038 Back-to-back req_valid_i held high for 3 requests -> exactly 3 accepts and 3 response pulses, with cyc never overlapping between transactions.
